// File: rtl/mrx_pkg.sv
// mrx_pkg: shared types for the mrx_sig receive aligner, plus the closed-form
// per-symbol phase plan used by both the phase generator and its bench model.
package mrx_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic [63:0] start_ph;
      logic [63:0] inc;
   } sym_ph_t;

   // Start phase and increment of 1-based symbol k; callers truncate to their phase width.
   function automatic sym_ph_t sym_ph(input logic [63:0] start_ph,
                                      input logic [63:0] start_inc,
                                      input logic [63:0] dph_inc,
                                      input logic [63:0] nph_shift,
                                      input logic [63:0] k);
      sym_ph_t r;
      r.start_ph = start_ph - (k - 64'd1) * nph_shift;
      r.inc      = start_inc + (k - 64'd1) * dph_inc;
      return r;
   endfunction

endpackage

// File: rtl/mrx_phase_gen.sv
// mrx_phase_gen: regenerates the transmitter's DDS phase walk one sample per advance
// and tracks the 1-based sample/symbol counters that frame it.
module mrx_phase_gen
   import mrx_pkg::*;
#(
   parameter int PHASE_WIDTH  = 24,
   parameter int NSYMB_WIDTH  = 16,
   parameter int NSYMB        = 512,
   parameter int NSIG         = 40960,
   parameter int DPH_INC      = 16384,
   parameter int START_PH_INC = 8192,
   parameter int START_PH     = 0,
   parameter int NPH_SHIFT    = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   restart,
   input  logic                   advance,
   output logic [PHASE_WIDTH-1:0] ref_phase,
   output logic                   last,
   output logic                   first,
   output logic                   frame_last,
   output logic [PHASE_WIDTH-1:0] sig_n,
   output logic [NSYMB_WIDTH-1:0] symb_n
);

   localparam sym_ph_t                SYM1     = sym_ph(64'(START_PH), 64'(START_PH_INC),
                                                        64'(DPH_INC), 64'(NPH_SHIFT), 64'd1);
   localparam logic [PHASE_WIDTH-1:0] INIT_PH  = PHASE_WIDTH'(SYM1.start_ph);
   localparam logic [PHASE_WIDTH-1:0] INIT_INC = PHASE_WIDTH'(SYM1.inc);
   localparam logic [PHASE_WIDTH-1:0] SHIFT    = PHASE_WIDTH'(NPH_SHIFT);
   localparam logic [PHASE_WIDTH-1:0] DINC     = PHASE_WIDTH'(DPH_INC);

   logic [PHASE_WIDTH-1:0] phase_q, phase_d, inc_q, inc_d, start_q, start_d, sig_q, sig_d;
   logic [NSYMB_WIDTH-1:0] symb_q, symb_d;

   assign last       = (sig_q == PHASE_WIDTH'(NSIG));
   assign frame_last = last && (symb_q == NSYMB_WIDTH'(NSYMB));
   assign first      = (sig_q == PHASE_WIDTH'(1)) && (symb_q == NSYMB_WIDTH'(1));
   assign ref_phase  = phase_q;
   assign sig_n      = sig_q;
   assign symb_n     = symb_q;

   always_comb begin
      phase_d = phase_q;
      inc_d   = inc_q;
      start_d = start_q;
      sig_d   = sig_q;
      symb_d  = symb_q;
      if (restart) begin
         phase_d = INIT_PH;
         inc_d   = INIT_INC;
         start_d = INIT_PH;
         sig_d   = PHASE_WIDTH'(1);
         symb_d  = NSYMB_WIDTH'(1);
      end else if (advance) begin
         if (last) begin
            sig_d = PHASE_WIDTH'(1);
            if (frame_last) begin
               symb_d  = NSYMB_WIDTH'(1);
               start_d = INIT_PH;
               inc_d   = INIT_INC;
               phase_d = INIT_PH;
            end else begin
               // Next symbol starts NPH_SHIFT earlier and steps DPH_INC faster.
               symb_d  = symb_q + NSYMB_WIDTH'(1);
               start_d = start_q - SHIFT;
               inc_d   = inc_q + DINC;
               phase_d = start_q - SHIFT;
            end
         end else begin
            sig_d   = sig_q + PHASE_WIDTH'(1);
            phase_d = phase_q + inc_q;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q <= INIT_PH;
         inc_q   <= INIT_INC;
         start_q <= INIT_PH;
         sig_q   <= PHASE_WIDTH'(1);
         symb_q  <= NSYMB_WIDTH'(1);
      end else begin
         phase_q <= phase_d;
         inc_q   <= inc_d;
         start_q <= start_d;
         sig_q   <= sig_d;
         symb_q  <= symb_d;
      end
   end

endmodule

// File: rtl/mrx_sig.sv
// mrx_sig: aligns the IQ stream to start_trig and tags each sample with the TX reference phase.
// Define MRX_SIG_ACC_EN to build the per-symbol integrate-and-dump on acc_i/acc_q/acc_valid.
module mrx_sig
   import mrx_pkg::*;
#(
   parameter int SAMP_WIDTH   = 16,
   parameter int PHASE_WIDTH  = 24,
   parameter int NSYMB_WIDTH  = 16,
   parameter int RX_SYNC_BITS = 2,
   parameter int ACC_WIDTH    = 32,
   parameter int NSYMB        = 512,
   parameter int NSIG         = 40960,
   parameter int DPH_INC      = 16384,
   parameter int START_PH_INC = 8192,
   parameter int START_PH     = 0,
   parameter int NPH_SHIFT    = 0
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                srst,
   input  logic                                start_trig,
   input  logic [2*SAMP_WIDTH-1:0]             in_tdata,
   input  logic                                in_tvalid,
   output logic                                in_tready,
   output logic [PHASE_WIDTH+2*SAMP_WIDTH-1:0] out_tdata,
   output logic                                out_tvalid,
   input  logic                                out_tready,
   output logic                                out_tlast,
   output logic                                out_tuser,
   output logic [ACC_WIDTH-1:0]                acc_i,
   output logic [ACC_WIDTH-1:0]                acc_q,
   output logic                                acc_valid,
   output logic                                sync_done,
   output logic                                locked,
   output logic [NSYMB_WIDTH-1:0]              symbN,
   output logic [PHASE_WIDTH-1:0]              sigN
);

   localparam int OUT_W = PHASE_WIDTH + 2*SAMP_WIDTH;

   state_t                  state_q, state_d;
   logic [RX_SYNC_BITS-1:0] frame_q, frame_d;
   logic [OUT_W-1:0]        data_q, data_d;
   logic                    vld_q, vld_d, last_q, last_d, user_q, user_d, sync_q, sync_d;
   logic                    slot_free, accept, fwd, frame_wrap;
   logic [PHASE_WIDTH-1:0]  ref_phase;
   logic                    gen_last, gen_first, gen_frame_last;

   mrx_phase_gen #(
      .PHASE_WIDTH (PHASE_WIDTH),
      .NSYMB_WIDTH (NSYMB_WIDTH),
      .NSYMB       (NSYMB),
      .NSIG        (NSIG),
      .DPH_INC     (DPH_INC),
      .START_PH_INC(START_PH_INC),
      .START_PH    (START_PH),
      .NPH_SHIFT   (NPH_SHIFT)
   ) u_gen (
      .clk       (clk),
      .reset     (reset),
      .restart   (srst),
      .advance   (fwd),
      .ref_phase (ref_phase),
      .last      (gen_last),
      .first     (gen_first),
      .frame_last(gen_frame_last),
      .sig_n     (sigN),
      .symb_n    (symbN)
   );

   assign slot_free = out_tready | ~vld_q;
   assign accept    = in_tvalid & in_tready;
   // A trigger arriving while the previous period's final beat is still stalled is not
   // taken, so that beat is never overwritten.
   assign fwd        = accept & ((state_q == RUN) | (start_trig & slot_free));
   assign frame_wrap = fwd & gen_frame_last & (&frame_q);

   always_comb begin
      state_d = state_q;
      if (srst) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (fwd) state_d = RUN;
            RUN:     if (frame_wrap) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      in_tready = 1'b1;
      locked    = 1'b0;
      if (state_q == RUN) begin
         in_tready = slot_free;
         locked    = 1'b1;
      end
   end

   always_comb begin
      data_d  = data_q;
      vld_d   = vld_q;
      last_d  = last_q;
      user_d  = user_q;
      frame_d = frame_q;
      sync_d  = 1'b0;
      if (srst) begin
         data_d  = '0;
         vld_d   = 1'b0;
         last_d  = 1'b0;
         user_d  = 1'b0;
         frame_d = '0;
      end else begin
         if (out_tready) vld_d = 1'b0;
         if (fwd) begin
            data_d = {ref_phase, in_tdata};
            vld_d  = 1'b1;
            last_d = gen_last;
            user_d = gen_first;
         end
         if (fwd && gen_frame_last) frame_d = frame_q + RX_SYNC_BITS'(1);
         sync_d = frame_wrap;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         frame_q <= '0;
         data_q  <= '0;
         vld_q   <= 1'b0;
         last_q  <= 1'b0;
         user_q  <= 1'b0;
         sync_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         data_q  <= data_d;
         vld_q   <= vld_d;
         last_q  <= last_d;
         user_q  <= user_d;
         sync_q  <= sync_d;
      end
   end

   assign out_tdata  = data_q;
   assign out_tvalid = vld_q;
   assign out_tlast  = last_q;
   assign out_tuser  = user_q;
   assign sync_done  = sync_q;

`ifdef MRX_SIG_ACC_EN
   logic signed [SAMP_WIDTH-1:0] samp_i, samp_q;
   logic signed [ACC_WIDTH-1:0]  run_i_q, run_i_d, run_q_q, run_q_d;
   logic signed [ACC_WIDTH-1:0]  sum_i_q, sum_i_d, sum_q_q, sum_q_d, nxt_i, nxt_q;
   logic                         accv_q, accv_d;

   assign samp_i = in_tdata[2*SAMP_WIDTH-1:SAMP_WIDTH];
   assign samp_q = in_tdata[SAMP_WIDTH-1:0];
   assign nxt_i  = run_i_q + ACC_WIDTH'(samp_i);
   assign nxt_q  = run_q_q + ACC_WIDTH'(samp_q);

   always_comb begin
      run_i_d = run_i_q;
      run_q_d = run_q_q;
      sum_i_d = sum_i_q;
      sum_q_d = sum_q_q;
      accv_d  = 1'b0;
      if (srst) begin
         run_i_d = '0;
         run_q_d = '0;
         sum_i_d = '0;
         sum_q_d = '0;
      end else if (fwd) begin
         if (gen_last) begin
            sum_i_d = nxt_i;
            sum_q_d = nxt_q;
            run_i_d = '0;
            run_q_d = '0;
            accv_d  = 1'b1;
         end else begin
            run_i_d = nxt_i;
            run_q_d = nxt_q;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run_i_q <= '0;
         run_q_q <= '0;
         sum_i_q <= '0;
         sum_q_q <= '0;
         accv_q  <= 1'b0;
      end else begin
         run_i_q <= run_i_d;
         run_q_q <= run_q_d;
         sum_i_q <= sum_i_d;
         sum_q_q <= sum_q_d;
         accv_q  <= accv_d;
      end
   end

   assign acc_i     = sum_i_q;
   assign acc_q     = sum_q_q;
   assign acc_valid = accv_q;
`else
   assign acc_i     = '0;
   assign acc_q     = '0;
   assign acc_valid = 1'b0;
`endif

endmodule
